// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant with a forced dead
// cycle between owners and a bounded hold time.
module onehot_rr_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         release_i,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         busy,
    output logic         timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W:0]    N_W      = (PTR_W + 1)'(N);
    localparam logic [PTR_W-1:0]  LAST     = PTR_W'(N - 1);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N-1:0]      grant_q, grant_d;
    logic              timeout_q, timeout_d;

    logic              found;
    logic [PTR_W-1:0]  pick;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  idx;
    logic              hold_expired;
    logic              owner_req;

    // Circular priority scan starting at the pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign hold_expired = (hold_q == HOLD_END);
    assign owner_req    = req[owner_q];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = GRANT;
                    owner_d        = pick;
                    hold_d         = '0;
                    grant_d        = '0;
                    grant_d[pick]  = 1'b1;
                end
            end
            GRANT: begin
                if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
                if (release_i || !owner_req || hold_expired) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    ptr_d     = (owner_q == LAST) ? '0 : owner_q + 1'b1;
                    // Timeout flags only a release forced by the hold counter.
                    timeout_d = hold_expired && !release_i && owner_req;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign busy        = (state_q == GRANT);
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: directed scenarios plus a random soak, checked
// every cycle against a behavioural round-robin model.
module tb_onehot_rr_arbiter;

    localparam int N        = 16;
    localparam int MAX_HOLD = 4;
    localparam int PW       = $clog2(N);

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic [N-1:0] req       = '0;
    logic         release_i = 1'b0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic         busy;
    logic         timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    onehot_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .release_i   (release_i),
        .grant       (grant),
        .grant_valid (grant_valid),
        .busy        (busy),
        .timeout     (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Behavioural model: owner index (-1 = none), cycles held, gap flag, pointer.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int o, p, h, c;
        bit g, t, rq;
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_held  <= 0;
            m_gap   <= 1'b0;
            m_to    <= 1'b0;
        end else begin
            o = m_owner;
            p = m_ptr;
            h = m_held;
            g = 1'b0;
            t = 1'b0;
            if (o >= 0) begin
                h  = h + 1;
                rq = req[PW'(o)];
                if (release_i || !rq || h == MAX_HOLD) begin
                    t = !release_i && rq && (h == MAX_HOLD);
                    p = (o + 1) % N;
                    o = -1;
                    g = 1'b1;
                end
            end else if (!m_gap && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    c = (p + k) % N;
                    if (o < 0 && req[PW'(c)]) o = c;
                end
                h = 0;
            end
            m_owner <= o;
            m_ptr   <= p;
            m_held  <= h;
            m_gap   <= g;
            m_to    <= t;
        end
    end

    logic [N-1:0] prev_g = '0;
    int           wcnt [N];

    always @(negedge clk) begin : cmp
        logic [31:0] eg;
        int          nw;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check("grant", 32'(grant), eg);
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        check("valid_vs_grant", 32'(grant_valid), 32'(|grant));
        if (prev_g != '0 && grant != '0) begin
            check("no_direct_switch", 32'(grant), 32'(prev_g));
        end
        for (int i = 0; i < N; i++) begin
            nw = wcnt[i];
            if (!rst_n || !req[i]) begin
                nw = 0;
            end else if (prev_g == '0 && grant != '0) begin
                if (grant[i]) begin
                    nw = 0;
                end else begin
                    nw = nw + 1;
                    check("fairness_bound", 32'(nw <= N), 32'd1);
                end
            end
            wcnt[i] <= nw;
        end
        prev_g <= rst_n ? grant : '0;
    end

    logic [N-1:0] t2_exp [4] = '{16'h0008, 16'h8000, 16'h0001, 16'h0008};

    initial begin
        int b;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // Single requester, released after three cycles.
        req = 16'h0004;
        tick();
        check("t1_grant", 32'(grant), 32'h0004);
        check("t1_valid", 32'(grant_valid), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check("t1_still_held", 32'(grant), 32'h0004);
        release_i = 1'b1;
        req       = '0;
        tick();
        release_i = 1'b0;
        check("t1_release", 32'(grant), 32'd0);
        check("t1_no_timeout", 32'(timeout), 32'd0);
        tick();

        // Pointer at 3: rotation through bits 3, 15, 0, 3.
        req = 16'h8009;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_grant", 32'(grant), 32'(t2_exp[k]));
            release_i = 1'b1;
            tick();
            release_i = 1'b0;
            check("t2_gap", 32'(grant), 32'd0);
            tick();
            check("t2_idle", 32'(grant), 32'd0);
        end
        req = '0;
        tick();

        // Hold timeout after MAX_HOLD cycles.
        req = 16'h0010;
        for (int k = 0; k < MAX_HOLD; k++) begin
            tick();
            check("t3_hold", 32'(grant), 32'h0010);
            check("t3_no_early_to", 32'(timeout), 32'd0);
        end
        tick();
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_gap", 32'(grant), 32'd0);
        tick();
        check("t3_to_pulse", 32'(timeout), 32'd0);
        check("t3_idle", 32'(grant), 32'd0);
        tick();
        check("t3_regrant", 32'(grant), 32'h0010);
        req = '0;
        tick();
        tick();

        // Owner withdraws while another request waits.
        req = 16'h0040;
        tick();
        check("t4_grant", 32'(grant), 32'h0040);
        req = 16'h0042;
        tick();
        check("t4_ignore_other", 32'(grant), 32'h0040);
        req = 16'h0002;
        tick();
        check("t4_withdraw", 32'(grant), 32'd0);
        check("t4_no_timeout", 32'(timeout), 32'd0);
        tick();
        check("t4_idle", 32'(grant), 32'd0);
        tick();
        check("t4_next", 32'(grant), 32'h0002);
        req = '0;
        tick();
        tick();

        // Asynchronous reset mid-grant; pointer returns to 0.
        req = 16'h0100;
        tick();
        check("t5_grant", 32'(grant), 32'h0100);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_grant", 32'(grant), 32'd0);
        check("t5_async_valid", 32'(grant_valid), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_timeout", 32'(timeout), 32'd0);
        tick();
        rst_n = 1'b1;
        req   = 16'h0101;
        tick();
        check("t5_ptr_reset", 32'(grant), 32'h0001);
        req = '0;
        tick();
        tick();

        // Random soak.
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = int'($urandom_range(0, N - 1));
                req[PW'(b)] = ~req[PW'(b)];
            end
            if ($urandom_range(0, 63) == 0) req = '0;
            release_i = ($urandom_range(0, 9) == 0);
            tick();
        end
        release_i = 1'b0;
        req       = '0;
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
